// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer between MEM stage and data RAM
// Optional perf counters (forward hits, stalls, drains) when DMEM_STBUF_PERF_EN is defined.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              cpu_addr_i,
  input  logic [31:0]                cpu_wdata_i,
  input  logic                       cpu_we_i,
  input  logic                       cpu_re_i,
  output logic [31:0]                cpu_rdata_o,
  output logic                       stall_o,
  output logic [AW-1:0]              ram_addr_o,
  output logic [31:0]                ram_wdata_o,
  output logic                       ram_we_o,
  input  logic                       ram_wready_i,
  input  logic [31:0]                ram_rdata_i,
`ifdef DMEM_STBUF_PERF_EN
  output logic [31:0]                perf_fwd_o,
  output logic [31:0]                perf_stall_o,
  output logic [31:0]                perf_drain_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          load, drain, full, enq;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] fwd_idx;

  // An illegal load+store cycle is handled as a plain store.
  assign load  = cpu_re_i & ~cpu_we_i;
  assign full  = (count_q == CW'(DEPTH));
  assign drain = ~rst & ~load & (count_q != '0) & ram_wready_i;
  assign enq   = ~rst & cpu_we_i & (~full | drain);

  assign stall_o     = ~rst & cpu_we_i & full & ~drain;
  assign ram_we_o    = drain;
  assign ram_addr_o  = drain ? {addr_q[head_q], 2'b00} : cpu_addr_i;
  assign ram_wdata_o = data_q[head_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr_i[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign cpu_rdata_o = (load & fwd_hit) ? fwd_data : ram_rdata_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(enq) - CW'(drain);
    if (drain) head_d = head_q + PW'(1);
    if (enq)   tail_d = tail_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_addr_i[AW-1:2];
      data_q[tail_q] <= cpu_wdata_i;
    end
  end

  a_no_load_store: assert property (@(posedge clk) disable iff (rst) !(cpu_we_i && cpu_re_i));

`ifdef DMEM_STBUF_PERF_EN
  logic [31:0] perf_fwd_q, perf_stall_q, perf_drain_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
      perf_drain_q <= '0;
    end else begin
      if (load && fwd_hit && perf_fwd_q != '1) perf_fwd_q <= perf_fwd_q + 32'd1;
      if (stall_o && perf_stall_q != '1)       perf_stall_q <= perf_stall_q + 32'd1;
      if (ram_we_o && perf_drain_q != '1)      perf_drain_q <= perf_drain_q + 32'd1;
    end
  end

  assign perf_fwd_o   = perf_fwd_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_drain_o = perf_drain_q;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_we_i, cpu_re_i, stall_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        ram_we_o, ram_wready_i, empty_o;
  logic [2:0]  count_o;
`ifdef DMEM_STBUF_PERF_EN
  logic [31:0] perf_fwd_o, perf_stall_o, perf_drain_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];
  logic [31:0] drain_log [$];

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_we_i(cpu_we_i), .cpu_re_i(cpu_re_i), .cpu_rdata_o(cpu_rdata_o),
    .stall_o(stall_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_wready_i(ram_wready_i), .ram_rdata_i(ram_rdata_i),
`ifdef DMEM_STBUF_PERF_EN
    .perf_fwd_o(perf_fwd_o), .perf_stall_o(perf_stall_o), .perf_drain_o(perf_drain_o),
`endif
    .count_o(count_o), .empty_o(empty_o)
  );

  // RAM model: async read, write at the clock edge.
  assign ram_rdata_i = mem[ram_addr_o[11:2]];
  always @(posedge clk) begin
    if (ram_we_o) begin
      mem[ram_addr_o[11:2]] <= ram_wdata_o;
      drain_log.push_back(ram_addr_o);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cpu_we_i = 1'b0; cpu_re_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we_i = 1'b1; cpu_re_i = 1'b0; cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic load(input logic [31:0] a);
    cpu_we_i = 1'b0; cpu_re_i = 1'b1; cpu_addr_i = a; cpu_wdata_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ram_wready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cpu_we_i = 1'($urandom_range(0, 1)); cpu_re_i = 1'($urandom_range(0, 1));
      cpu_addr_i = $urandom; cpu_wdata_i = $urandom; ram_wready_i = 1'($urandom_range(0, 1));
      #1;
      total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b exp 0", ram_we_o); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b exp 0", stall_o); end
      tick;
      total++; if (count_o !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d exp 0", count_o); end
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b exp 1", empty_o); end
    end
    rst = 1'b0; idle; ram_wready_i = 1'b1;
    #1;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL post_rst_count: got %0d exp 0", count_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL post_rst_empty: got %b exp 1", empty_o); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL post_rst_we: got %b exp 0", ram_we_o); end
    tick;
  endtask

  task automatic test_single_store;
    ram_wready_i = 1'b1;
    store(32'h100, 32'hDEADBEEF);
    #1;
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL st_latency: got %b exp 0", ram_we_o); end
    tick;
    idle; #1;
    total++; if (ram_we_o !== 1'b1) begin bad++; $display("FAIL st_we: got %b exp 1", ram_we_o); end
    total++; if (ram_addr_o !== 32'h100) begin bad++; $display("FAIL st_addr: got %h exp 100", ram_addr_o); end
    total++; if (ram_wdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL st_wdata: got %h exp deadbeef", ram_wdata_o); end
    tick;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL st_empty: got %b exp 1", empty_o); end
    load(32'h100); #1;
    total++; if (cpu_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL st_readback: got %h exp deadbeef", cpu_rdata_o); end
    tick; idle;
  endtask

  task automatic test_forwarding;
    ram_wready_i = 1'b0;
    store(32'h200, 32'd1); tick;
    store(32'h200, 32'd2); tick;
    load(32'h202); #1;
    total++; if (cpu_rdata_o !== 32'd2) begin bad++; $display("FAIL fwd_youngest: got %h exp 2", cpu_rdata_o); end
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL fwd_count: got %0d exp 2", count_o); end
    tick;
    load(32'h300); #1;
    total++; if (cpu_rdata_o !== 32'hA00000C0) begin bad++; $display("FAIL fwd_miss: got %h exp a00000c0", cpu_rdata_o); end
    tick;
    idle; ram_wready_i = 1'b1;
    tick; tick;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL fwd_drained: got %b exp 1", empty_o); end
    load(32'h200); #1;
    total++; if (cpu_rdata_o !== 32'd2) begin bad++; $display("FAIL fwd_ram_final: got %h exp 2", cpu_rdata_o); end
    tick; idle;
  endtask

  task automatic test_full_stall;
    ram_wready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      store(32'h400 + 32'(4 * k), 32'h40 + 32'(k)); tick;
    end
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_count: got %0d exp 4", count_o); end
    store(32'h410, 32'h44); #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL full_stall: got %b exp 1", stall_o); end
    tick;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL stall_count: got %0d exp 4", count_o); end
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL stall_hold: got %b exp 1", stall_o); end
    ram_wready_i = 1'b1; #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL unstall: got %b exp 0", stall_o); end
    total++; if (ram_we_o !== 1'b1) begin bad++; $display("FAIL unstall_we: got %b exp 1", ram_we_o); end
    total++; if (ram_addr_o !== 32'h400) begin bad++; $display("FAIL unstall_addr: got %h exp 400", ram_addr_o); end
    tick;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL enq_drain_count: got %0d exp 4", count_o); end
    idle;
    repeat (4) tick;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL full_drained: got %b exp 1", empty_o); end
    load(32'h410); #1;
    total++; if (cpu_rdata_o !== 32'h44) begin bad++; $display("FAIL fifth_store: got %h exp 44", cpu_rdata_o); end
    tick; idle;
  endtask

  task automatic test_back_to_back_loads;
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h500; exp_addr[1] = 32'h504; exp_addr[2] = 32'h508;
    ram_wready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(exp_addr[k], 32'h50 + 32'(k)); tick;
    end
    drain_log.delete();
    ram_wready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load(32'h600 + 32'(4 * k)); #1;
      total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL load_blocks_drain[%0d]: got %b exp 0", k, ram_we_o); end
      tick;
    end
    load(32'h504); #1;
    total++; if (cpu_rdata_o !== 32'h51) begin bad++; $display("FAIL b2b_fwd: got %h exp 51", cpu_rdata_o); end
    tick;
    idle;
    repeat (3) tick;
    total++; if (drain_log.size() !== 3) begin bad++; $display("FAIL drain_count: got %0d exp 3", drain_log.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < drain_log.size()) begin
        total++;
        if (drain_log[k] !== exp_addr[k]) begin bad++; $display("FAIL drain_order[%0d]: got %h exp %h", k, drain_log[k], exp_addr[k]); end
      end
    end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b exp 1", empty_o); end
  endtask

  task automatic test_mid_reset;
    ram_wready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(32'h700 + 32'(4 * k), 32'h70 + 32'(k)); tick;
    end
    idle;
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL pre_rst_count: got %0d exp 3", count_o); end
    drain_log.delete();
    rst = 1'b1; ram_wready_i = 1'b1; #1;
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %b exp 0", ram_we_o); end
    tick;
    rst = 1'b0; #1;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL mid_rst_count: got %0d exp 0", count_o); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL post_mid_rst_we: got %b exp 0", ram_we_o); end
    tick;
    load(32'h704); #1;
    total++; if (cpu_rdata_o !== 32'hA00001C1) begin bad++; $display("FAIL discarded_store: got %h exp a00001c1", cpu_rdata_o); end
    tick; idle; tick;
    total++; if (drain_log.size() !== 0) begin bad++; $display("FAIL no_writes_after_rst: got %0d exp 0", drain_log.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1; idle; ram_wready_i = 1'b0;
    test_reset;
    test_single_store;
    test_forwarding;
    test_full_stall;
    test_back_to_back_loads;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
